// File: rtl/iir_biquad_p.sv
// Parametrised direct-form-I biquad IIR: round-half-up, saturate or wrap output,
// coefficient capture on coef_ld, synchronous state flush and sticky overflow.
module iir_biquad_p #(
    parameter int W    = 9,
    parameter int CW   = 9,
    parameter int FRAC = 8,
    parameter int SAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din,
    input  logic          vin,
    input  logic [CW-1:0] b0,
    input  logic [CW-1:0] b1,
    input  logic [CW-1:0] b2,
    input  logic [CW-1:0] a1,
    input  logic [CW-1:0] a2,
    input  logic          coef_ld,
    input  logic          clr,
    output logic [W-1:0]  dout,
    output logic          vout,
    output logic          ovf
);
    localparam int STAGES = 1;
    localparam int AW     = W + CW + 3;
    localparam logic signed [AW-1:0] HALF = (FRAC > 0) ? (AW'(1) << (FRAC - 1)) : '0;
    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic signed [CW-1:0] cb0, cb1, cb2, ca1, ca2;
    logic signed [W-1:0]  x1, x2, y1, y2;
    logic signed [AW-1:0] acc, sh;
    logic [W-1:0]         yq;
    logic                 hi, lo;
    logic [STAGES:0]      vld_pipe;

    // Operands are sign-extended to the accumulator width so the product is exact.
    function automatic logic signed [AW-1:0] mulx(input logic signed [CW-1:0] c,
                                                  input logic signed [W-1:0] d);
        logic signed [AW-1:0] ce, de;
        ce = {{(AW-CW){c[CW-1]}}, c};
        de = {{(AW-W){d[W-1]}}, d};
        return ce * de;
    endfunction

    always_comb begin
        acc = mulx(cb0, $signed(din)) + mulx(cb1, x1) + mulx(cb2, x2)
            - mulx(ca1, y1) - mulx(ca2, y2);
        sh  = (acc + HALF) >>> FRAC;
        hi  = (sh > MAXV);
        lo  = (sh < MINV);
        yq  = sh[W-1:0];
        if (SAT != 0) begin
            if (hi)
                yq = {1'b0, {(W-1){1'b1}}};
            else if (lo)
                yq = {1'b1, {(W-1){1'b0}}};
        end
    end

    assign vld_pipe[0] = vin & ~clr;
    assign vout        = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            dout <= '0;
            ovf  <= 1'b0;
            x1   <= '0;
            x2   <= '0;
            y1   <= '0;
            y2   <= '0;
            cb0  <= '0;
            cb1  <= '0;
            cb2  <= '0;
            ca1  <= '0;
            ca2  <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            // A sample arriving with coef_ld still sees the old coefficients.
            if (coef_ld) begin
                cb0 <= $signed(b0);
                cb1 <= $signed(b1);
                cb2 <= $signed(b2);
                ca1 <= $signed(a1);
                ca2 <= $signed(a2);
            end
            if (clr) begin
                x1 <= '0;
                x2 <= '0;
                y1 <= '0;
                y2 <= '0;
            end else if (vin) begin
                dout <= yq;
                ovf  <= ovf | hi | lo;
                x2   <= x1;
                x1   <= $signed(din);
                y2   <= y1;
                y1   <= $signed(yq);
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_p.sv
// Directed bench for iir_biquad_p: saturating and wrapping instances share stimulus,
// expected outputs are queued per accepted sample and checked when vout appears.
module tb_iir_biquad_p;
    logic       clk, rst, vin, coef_ld, clr;
    logic [8:0] din, b0, b1, b2, a1, a2;
    logic [8:0] dout_s, dout_w;
    logic       vout_s, vout_w, ovf_s, ovf_w;

    typedef struct {
        int es;
        int ew;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [8:0] last_s, last_w;

    iir_biquad_p #(.W(9), .CW(9), .FRAC(8), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .din(din), .vin(vin),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .coef_ld(coef_ld), .clr(clr),
        .dout(dout_s), .vout(vout_s), .ovf(ovf_s)
    );

    iir_biquad_p #(.W(9), .CW(9), .FRAC(8), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .din(din), .vin(vin),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .coef_ld(coef_ld), .clr(clr),
        .dout(dout_w), .vout(vout_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2, input int c3, input int c4);
        b0 = 9'(c0);
        b1 = 9'(c1);
        b2 = 9'(c2);
        a1 = 9'(c3);
        a2 = 9'(c4);
    endtask

    // One clock: drive, take the edge, then check vout/dout 1 time unit later.
    task automatic cyc(input logic v, input int d, input int es, input int ew,
                       input logic c, input logic ld, input logic r);
        exp_t e;
        logic acc_v;
        din     = 9'(d);
        vin     = v;
        clr     = c;
        coef_ld = ld;
        rst     = r;
        acc_v   = v && !c && !r;
        if (acc_v) q.push_back('{es, ew});
        last_s = dout_s;
        last_w = dout_w;
        @(posedge clk);
        #1;
        chk("vout_sat", int'(vout_s), int'(acc_v));
        chk("vout_wrap", int'(vout_w), int'(acc_v));
        if (vout_s) begin
            if (q.size() == 0) begin
                chk("queue_empty", 1, 0);
            end else begin
                e = q.pop_front();
                chk("dout_sat", int'($signed(dout_s)), e.es);
                chk("dout_wrap", int'($signed(dout_w)), e.ew);
            end
        end else if (!r) begin
            chk("hold_sat", int'(dout_s), int'(last_s));
            chk("hold_wrap", int'(dout_w), int'(last_w));
        end
        vin = 1'b0; clr = 1'b0; coef_ld = 1'b0; rst = 1'b0;
    endtask

    initial begin
        din = '0; vin = 0; clr = 0; coef_ld = 0; rst = 1;
        set_coef(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst_dout", int'(dout_s), 0);
        chk("rst_ovf", int'(ovf_s), 0);
        chk("rst_ovf_w", int'(ovf_w), 0);

        // Zero coefficients after reset give zero output
        cyc(1, 150, 0, 0, 0, 0, 0);

        // Rounding with b0 = 0.5
        set_coef(128, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 200, 100, 100, 0, 0, 0);
        cyc(1, 201, 101, 101, 0, 0, 0);
        cyc(1, -201, -100, -100, 0, 0, 0);

        // coef_ld with a valid sample: that sample still uses b0 only (new would give 50)
        set_coef(128, 0, 0, -128, 0);
        cyc(1, 200, 100, 100, 0, 1, 0);

        // Flush then recursive step response
        cyc(1, 200, 0, 0, 1, 0, 0);
        cyc(1, 200, 100, 100, 0, 0, 0);
        cyc(1, 200, 150, 150, 0, 0, 0);
        cyc(1, 200, 175, 175, 0, 0, 0);
        cyc(1, 200, 0, 0, 1, 0, 0);
        cyc(1, 200, 100, 100, 0, 0, 0);
        // Same sequence with gaps: dout holds, values unchanged
        cyc(1, 200, 150, 150, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 200, 175, 175, 0, 0, 0);
        cyc(1, 200, 188, 188, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 200, 194, 194, 0, 0, 0);
        chk("ovf_inrange", int'(ovf_s), 0);

        // Reset mid-stream discards the sample and zeroes coefficients
        cyc(1, 200, 0, 0, 0, 0, 1);
        chk("rst_mid_dout", int'(dout_s), 0);
        cyc(1, 200, 0, 0, 0, 0, 0);
        set_coef(128, 0, 0, -128, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 200, 100, 100, 0, 0, 0);
        cyc(1, 200, 150, 150, 0, 0, 0);

        // Saturate vs wrap
        set_coef(255, 255, 255, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        cyc(1, 255, 254, 254, 0, 0, 0);
        chk("ovf_first", int'(ovf_s), 0);
        chk("ovf_first_w", int'(ovf_w), 0);
        cyc(1, 255, 255, -4, 0, 0, 0);
        chk("ovf_second", int'(ovf_s), 1);
        chk("ovf_second_w", int'(ovf_w), 1);
        cyc(1, 255, 255, 250, 0, 0, 0);
        // Negative clamp
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, -256, -255, -255, 0, 0, 0);
        cyc(1, -256, -256, 2, 0, 0, 0);
        chk("ovf_sticky", int'(ovf_s), 1);

        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_rst", int'(ovf_s), 0);
        chk("ovf_rst_w", int'(ovf_w), 0);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iir_biquad_p.md
# iir_biquad_p

Parametrised second-order (biquad) IIR filter core, the next generation of the team's fixed 9-bit IIR. It generalises data and coefficient widths and fixed-point format. It adds selectable saturate/wrap output arithmetic, round-to-nearest, coefficient capture on a load strobe, a synchronous state flush and a sticky overflow flag. It sits between the sample source (data_maker-style, valid-qualified samples) and the sample sink, one sample per valid cycle.

## Interface
- W, default 9: data width (din, dout), two's complement
- CW, default 9: coefficient width, two's complement
- FRAC, default 8: fractional bits of coefficients; products are scaled by 2^-FRAC
- SAT, default 1: 1 = saturate output to W-bit range, 0 = two's-complement wrap
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- din  in  W  input sample x[n], valid when vin=1
- vin  in  1  input valid
- b0, b1, b2, a1, a2  in  CW each  coefficients, sampled only when coef_ld=1
- coef_ld  in  1  capture all five coefficient inputs into internal registers
- clr  in  1  synchronous flush of filter state (delay lines)
- dout  out  W  output sample y[n], registered
- vout  out  1  output valid
- ovf  out  1  sticky overflow: set when any output was saturated/wrapped

## Operation
- Direct form I: y[n] = Q( b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] ).
- Delay lines x1, x2, y1, y2 are W bits; y1/y2 hold the final W-bit dout (post-saturation/wrap).
- Products are full precision (W+CW bits, signed). Accumulate in W+CW+3 bits; no intermediate overflow is possible.
- Q(): add 2^(FRAC−1) (round half up), arithmetic shift right FRAC, then reduce to W bits.
  - SAT=1: clamp to [−2^(W−1), 2^(W−1)−1].
  - SAT=0: keep the low W bits.
  - In either mode, ovf is set if the shifted value lies outside the W-bit range.
- On a vin=1 cycle: compute with the current delay lines and coefficient registers. Register dout. Shift x2←x1, x1←din, y2←y1, y1←new dout.
- On a vin=0 cycle: delay lines, dout and ovf hold.
- coef_ld=1: internal coefficient registers load on that edge.
  - A sample with vin=1 in the same cycle uses the old coefficients.
  - The new coefficients apply from the next valid sample.
- clr=1: x1, x2, y1, y2 ← 0 and vout ← 0. clr has priority over vin, and that cycle's sample is discarded.
  - dout, ovf and the coefficients are unaffected.
- Priority: rst > clr > vin. coef_ld is independent of clr and vin.
- No state machine beyond valid pipeline. Coefficient inputs are ignored when coef_ld=0.

## Timing
- Latency: 1 cycle. din/vin at edge k produce dout/vout at edge k+1.
- vout is high for exactly one cycle per accepted sample, and is 0 the cycle after vin=0 or clr=1.
- Throughput: 1 sample/cycle, back-to-back vin allowed. Gaps in vin do not alter results.
- Reset values, applied on the rst edge: dout=0, vout=0, ovf=0, x1=x2=y1=y2=0, coefficient registers=0.
  - With all-zero coefficients, the output is 0 until coef_ld.
- Reset mid-stream: a sample presented with rst=1 is discarded, and the next output uses zero history.
- ovf clears only on rst.

## Test plan
- Rounding, W=9, CW=9, FRAC=8: load b0=128 (others 0); din=200 → dout=100; din=201 → dout=101 (100.5 rounds up); din=−201 → dout=−100.
- Recursive step: b0=128, a1=−128 (others 0); din=200 constant → dout 100, 150, 175, 188, … converging to 200; vout follows vin by one cycle.
- Saturation: b0=b1=b2=255, a1=a2=0, din=255 constant.
  - SAT=1: dout 254, 255, 255; ovf rises on the 2nd output.
  - SAT=0: dout 254, −4, 250; ovf set likewise.
- Valid gaps/coef timing: repeat the recursive-step test with vin toggling 1,0,0,1; outputs are identical, and dout holds during gaps. coef_ld asserted with vin=1 → that sample uses the old coefficients.
- clr/rst mid-stream: after 3 outputs of the recursive-step test, pulse clr with vin=1 → no vout that cycle; next din=200 → dout=100. Repeat with rst: all outputs reset to 0, and coefficients must be reloaded.
